// File: rtl/tdm_pkg.sv
// Shared types and default geometry for the TDM lane receiver.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  localparam int TDM_NUM_LANES = 4;
  localparam int TDM_LANE_W    = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the TDM receiver: clear, load-to-1 and wrapping increment.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NUM_LANES = TDM_NUM_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         load1_i,
  input  logic                         inc_i,
  output logic [$clog2(NUM_LANES)-1:0] slot_o
);

  localparam int SW = $clog2(NUM_LANES);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_LANES - 1);

  logic [SW-1:0] slot_q, slot_d;

  // Clear wins over load, load wins over increment.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SW'(1);
    end else if (inc_i) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_lane_rx.sv
// TDM lane receiver: demultiplexes a shared nibble bus into NUM_LANES slots per frame.
// Optional odd-parity checking is built when TDM_LANE_RX_PARITY_EN is defined.
module tdm_lane_rx
  import tdm_pkg::*;
#(
  parameter int NUM_LANES = TDM_NUM_LANES,
  parameter int LANE_W    = TDM_LANE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [LANE_W-1:0]           nib_in,
  input  logic                        nib_valid,
  input  logic                        frame_sync,
`ifdef TDM_LANE_RX_PARITY_EN
  input  logic                        nib_par,
  output logic                        par_err,
`endif
  output logic [NUM_LANES*LANE_W-1:0] lanes,
  output logic                        frame_done,
  output logic                        sync_err,
  output logic                        locked
);

  localparam int SW = $clog2(NUM_LANES);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_LANES - 1);

  tdm_state_e state_q, state_d;
  logic [NUM_LANES-1:0][LANE_W-1:0] shadow_q, shadow_d;
  logic [NUM_LANES-1:0][LANE_W-1:0] lanes_q, lanes_d;
  logic frame_done_q, frame_done_d;
  logic sync_err_q, sync_err_d;
  logic [SW-1:0] slot;
  logic slot_clr, slot_load1, slot_inc;
  logic beat;
  logic par_bad;

  assign beat = nib_valid & enable;

`ifdef TDM_LANE_RX_PARITY_EN
  logic par_err_q, par_err_d;
  // Parity only matters for beats the FSM would otherwise act on.
  assign par_bad = ~(^{nib_in, nib_par}) & ((state_q == RECV) | frame_sync);
`else
  assign par_bad = 1'b0;
`endif

  tdm_slot_ctr #(
    .NUM_LANES (NUM_LANES)
  ) u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (slot_clr),
    .load1_i (slot_load1),
    .inc_i   (slot_inc),
    .slot_o  (slot)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    lanes_d      = lanes_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    slot_clr     = 1'b0;
    slot_load1   = 1'b0;
    slot_inc     = 1'b0;
`ifdef TDM_LANE_RX_PARITY_EN
    par_err_d    = 1'b0;
`endif
    if (beat) begin
      if (par_bad) begin
`ifdef TDM_LANE_RX_PARITY_EN
        par_err_d = 1'b1;
`endif
        state_d  = HUNT;
        slot_clr = 1'b1;
      end else if (state_q == HUNT) begin
        if (frame_sync) begin
          shadow_d[0] = nib_in;
          slot_load1  = 1'b1;
          state_d     = RECV;
        end
      end else if (frame_sync) begin
        // A sync mid-frame restarts the frame; at slot 0 it is the expected start.
        sync_err_d  = (slot != '0);
        shadow_d[0] = nib_in;
        slot_load1  = 1'b1;
      end else if (slot == '0) begin
        sync_err_d = 1'b1;
        state_d    = HUNT;
      end else begin
        shadow_d[slot] = nib_in;
        slot_inc       = 1'b1;
        if (slot == LAST_SLOT) begin
          lanes_d      = shadow_d;
          frame_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      lanes_q      <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      lanes_q      <= lanes_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef TDM_LANE_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign lanes      = lanes_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == RECV);

endmodule

// File: tb/tb_tdm_lane_rx.sv
// Scoreboard bench for tdm_lane_rx: directed framing cases plus randomized traffic.
module tb_tdm_lane_rx;

  localparam int N = tdm_pkg::TDM_NUM_LANES;
  localparam int W = tdm_pkg::TDM_LANE_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic nib_valid = 1'b0;
  logic frame_sync = 1'b0;
  logic [W-1:0] nib_in = '0;
  logic [N*W-1:0] lanes;
  logic frame_done, sync_err, locked;
  logic pulse_par;

`ifdef TDM_LANE_RX_PARITY_EN
  logic nib_par = 1'b1;
  logic par_err;
  assign pulse_par = par_err;
`else
  assign pulse_par = 1'b0;
`endif

  tdm_lane_rx #(
    .NUM_LANES (N),
    .LANE_W    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .nib_in     (nib_in),
    .nib_valid  (nib_valid),
    .frame_sync (frame_sync),
`ifdef TDM_LANE_RX_PARITY_EN
    .nib_par    (nib_par),
    .par_err    (par_err),
`endif
    .lanes      (lanes),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = frame committed, 1 = sync error, 2 = parity error
  typedef struct {
    int             kind;
    logic [N*W-1:0] lanes;
    logic           locked;
    int             cyc;
  } ev_t;

  ev_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame in progress is simply the list of nibbles received so far.
  logic [W-1:0]   m_frame[$];
  bit             m_locked = 1'b0;
  logic [N*W-1:0] m_lanes = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic lk);
    ev_t ev;
    ev.kind   = kind;
    ev.lanes  = m_lanes;
    ev.locked = lk;
    ev.cyc    = cyc + 1;
    exp_q.push_back(ev);
  endtask

  task automatic model_beat(input logic [W-1:0] nib, input bit sync, input bit bad_par);
    if (!m_locked && !sync) return;
    if (bad_par) begin
      m_frame.delete();
      m_locked = 1'b0;
      push_ev(2, 1'b0);
      return;
    end
    if (sync) begin
      if (m_locked && m_frame.size() != 0) push_ev(1, 1'b1);
      m_frame.delete();
      m_frame.push_back(nib);
      m_locked = 1'b1;
    end else if (m_frame.size() == 0) begin
      m_locked = 1'b0;
      push_ev(1, 1'b0);
    end else begin
      m_frame.push_back(nib);
      if (m_frame.size() == N) begin
        for (int k = 0; k < N; k++) m_lanes[k*W +: W] = m_frame[k];
        m_frame.delete();
        push_ev(0, 1'b1);
      end
    end
  endtask

  task automatic drive(input logic [W-1:0] nib, input bit sync, input bit valid,
                       input bit en, input bit bad_par);
    @(posedge clk);
    #1;
    nib_in     = nib;
    frame_sync = sync;
    nib_valid  = valid;
    enable     = en;
`ifdef TDM_LANE_RX_PARITY_EN
    nib_par    = (~(^nib)) ^ bad_par;
`endif
    if (valid && en) model_beat(nib, sync, bad_par);
  endtask

  task automatic idle();
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic beat(input logic [W-1:0] nib, input bit sync, input int gap);
    drive(nib, sync, 1'b1, 1'b1, 1'b0);
    for (int g = 0; g < gap; g++) idle();
  endtask

  task automatic do_reset();
    idle();
    idle();
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_lanes", lanes, '0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_locked", locked, 1'b0);
    m_frame.delete();
    m_locked = 1'b0;
    m_lanes  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every pulse must match the oldest expected event; lanes must hold between commits.
  logic [N*W-1:0] mon_lanes = '0;
  ev_t mon_ev;
  int  act_kind;

  always @(negedge clk) begin
    if (rst) begin
      mon_lanes = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missed_event: kind %0d due cycle %0d, nothing seen by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (frame_done || sync_err || pulse_par) begin
        act_kind = frame_done ? 0 : (sync_err ? 1 : 2);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", act_kind, cyc);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_kind", 64'(act_kind), 64'(mon_ev.kind));
          check("event_cycle", 64'(cyc), 64'(mon_ev.cyc));
          check("event_lanes", lanes, mon_ev.lanes);
          check("event_locked", locked, mon_ev.locked);
          if (mon_ev.kind == 0) mon_lanes = mon_ev.lanes;
        end
      end
      check("lanes_hold", lanes, mon_lanes);
    end
  end

  logic [W-1:0] rn;
  bit rv, ren, rs;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("init_lanes", lanes, '0);
    check("init_locked", locked, 1'b0);
    check("init_frame_done", frame_done, 1'b0);
    check("init_sync_err", sync_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Clean back-to-back frame
    beat(4'h3, 1'b1, 0); beat(4'h7, 1'b0, 0); beat(4'hA, 1'b0, 0); beat(4'hF, 1'b0, 0);
    idle(); idle();
    check("clean_lanes", lanes, 16'hFA73);
    check("clean_locked", locked, 1'b1);

    // Same frame with idle gaps
    beat(4'h3, 1'b1, 2); beat(4'h7, 1'b0, 2); beat(4'hA, 1'b0, 2); beat(4'hF, 1'b0, 2);
    check("gapped_lanes", lanes, 16'hFA73);

    // Resync mid-frame
    beat(4'h1, 1'b1, 0); beat(4'h2, 1'b0, 0);
    beat(4'h5, 1'b1, 0); beat(4'h6, 1'b0, 0); beat(4'h7, 1'b0, 0); beat(4'h8, 1'b0, 0);
    idle(); idle();
    check("resync_lanes", lanes, 16'h8765);

    // Missing sync at frame start, then stray beats ignored
    beat(4'h9, 1'b0, 1); beat(4'h4, 1'b0, 0); beat(4'hB, 1'b0, 1);
    check("nosync_locked", locked, 1'b0);
    check("nosync_lanes", lanes, 16'h8765);

    // Enable low freezes everything, including a would-be sync beat
    drive(4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(); idle();
    check("disabled_locked", locked, 1'b0);

    // Reset mid-frame, then non-sync beats must be dropped silently
    beat(4'h3, 1'b1, 0); beat(4'h7, 1'b0, 0);
    do_reset();
    beat(4'h4, 1'b0, 0); beat(4'h5, 1'b0, 1);
    check("postrst_locked", locked, 1'b0);
    check("postrst_lanes", lanes, '0);

`ifdef TDM_LANE_RX_PARITY_EN
    beat(4'h3, 1'b1, 0); beat(4'h7, 1'b0, 0); beat(4'hA, 1'b0, 0); beat(4'hF, 1'b0, 0);
    drive(4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(4'h2, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(4'h3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(); idle();
    check("par_lanes", lanes, 16'hFA73);
    check("par_locked", locked, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rn  = W'($urandom_range(0, (1 << W) - 1));
      rv  = ($urandom_range(0, 9) < 6);
      ren = ($urandom_range(0, 9) != 0);
      rs  = (m_frame.size() == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      drive(rn, rs, rv, ren, 1'b0);
    end

    idle(); idle(); idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
